ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue.sv | 152 +++++++++++++++
 tb/tb_ifetch_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Sequential instruction fetcher with a small PC-tagged FIFO and redirect flush.
// Define IFQ_BYPASS_EN to let an acked word reach the consumer in the same cycle when the FIFO is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    // state | meaning
    // IDLE  | no request outstanding; waiting for FIFO credit
    // REQ   | request outstanding; acked word is pushed
    // DRAIN | request outstanding from before a redirect; acked word dropped
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          fifo_valid;
    logic          ack_live;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic          credit;
    logic [31:0]   fetch_pc_next;

    assign fifo_valid = (count != '0);
    assign ack_live   = (state == REQ) && mem_ack;

    always_comb begin
        instr_valid = fifo_valid;
        instr       = fifo_data[rd_ptr];
        instr_pc    = fifo_pc[rd_ptr];
        bypass_take = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (!fifo_valid && ack_live && !redirect) begin
            instr_valid = 1'b1;
            instr       = mem_rdata;
            instr_pc    = mem_addr;
            bypass_take = instr_ready;
        end
`endif
    end

    assign push = ack_live && !redirect && !bypass_take;
    assign pop  = fifo_valid && instr_ready;

    always_comb begin
        if (redirect)
            count_next = '0;
        else
            count_next = count + CW'(push) - CW'(pop);
    end

    // Credit is judged on the occupancy after this cycle's push/pop, so an ack can never overflow.
    assign credit = (count_next < CW'(DEPTH));

    always_comb begin
        if (redirect)
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
        else if (ack_live)
            fetch_pc_next = fetch_pc + 32'd4;
        else
            fetch_pc_next = fetch_pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            count <= count_next;
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_pc[wr_ptr]   <= mem_addr;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (redirect)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_next;
            case (state)
                IDLE: begin
                    if (!redirect && credit) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (credit) begin
                            mem_addr <= fetch_pc_next;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_addr <= fetch_pc_next;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, async-reset and address-wrap sequences,
// then randomized traffic against a queue-based reference model.
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    logic        reset_b = 1'b0;
    logic        mem_req_b;
    logic [31:0] mem_addr_b;
    logic        mem_ack_b = 1'b0;
    logic [31:0] mem_rdata_b = '0;
    logic        instr_valid_b;
    logic [31:0] instr_b;
    logic [31:0] instr_pc_b;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    ifetch_queue #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .redirect(1'b0),
        .redirect_pc(32'h0), .instr_valid(instr_valid_b), .instr(instr_b),
        .instr_pc(instr_pc_b), .instr_ready(1'b1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    typedef struct {
        bit          rst;
        bit          ack;
        bit          rdy;
        bit          rdr;
        logic [31:0] rpc;
        bit          bad_data;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input bit rst, input bit ack, input bit rdy, input bit rdr,
                               input logic [31:0] rpc, input bit bd, input bit e_req,
                               input logic [31:0] e_addr, input bit e_val, input logic [31:0] e_pc);
        vec_t r;
        r.rst = rst; r.ack = ack; r.rdy = rdy; r.rdr = rdr; r.rpc = rpc; r.bad_data = bd;
        r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        mem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_pc = '0;
        reset = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // rst ack rdy rdr rpc bad | req addr val pc
        tv.push_back(v(1,1,1,0,0,0, 1,32'h0,  0,32'h0));
        tv.push_back(v(0,0,1,0,0,0, 1,32'h4,  1,32'h0));
        tv.push_back(v(0,1,1,0,0,0, 1,32'h4,  0,32'h0));
        tv.push_back(v(0,0,1,0,0,0, 1,32'h8,  1,32'h4));
        tv.push_back(v(0,1,1,0,0,0, 1,32'h8,  0,32'h0));
        tv.push_back(v(0,0,1,0,0,0, 1,32'hC,  1,32'h8));
        tv.push_back(v(0,1,1,0,0,0, 1,32'hC,  0,32'h0));
        tv.push_back(v(0,0,0,0,0,0, 1,32'h10, 1,32'hC));
        tv.push_back(v(1,1,0,0,0,0, 1,32'h0,  0,32'h0));
        tv.push_back(v(0,1,0,0,0,0, 1,32'h4,  1,32'h0));
        tv.push_back(v(0,1,0,0,0,0, 1,32'h8,  1,32'h0));
        tv.push_back(v(0,1,0,0,0,0, 1,32'hC,  1,32'h0));
        tv.push_back(v(0,0,0,0,0,0, 0,32'h0,  1,32'h0));
        tv.push_back(v(0,0,0,0,0,0, 0,32'h0,  1,32'h0));
        tv.push_back(v(0,0,1,0,0,0, 0,32'h0,  1,32'h0));
        tv.push_back(v(0,0,0,0,0,0, 1,32'h10, 1,32'h4));
        tv.push_back(v(0,1,0,0,0,0, 1,32'h10, 1,32'h4));
        tv.push_back(v(0,0,0,0,0,0, 0,32'h0,  1,32'h4));
        tv.push_back(v(1,1,1,0,0,0,          1,32'h0,   0,32'h0));
        tv.push_back(v(0,1,1,0,0,0,          1,32'h4,   1,32'h0));
        tv.push_back(v(0,0,1,1,32'h103,0,    1,32'h8,   1,32'h4));
        tv.push_back(v(0,0,1,0,0,0,          1,32'h8,   0,32'h0));
        tv.push_back(v(0,0,1,0,0,0,          1,32'h8,   0,32'h0));
        tv.push_back(v(0,1,1,0,0,1,          1,32'h8,   0,32'h0));
        tv.push_back(v(0,1,1,0,0,0,          1,32'h100, 0,32'h0));
        tv.push_back(v(0,0,1,0,0,0,          1,32'h104, 1,32'h100));
        tv.push_back(v(1,1,0,0,0,0,          1,32'h0,   0,32'h0));
        tv.push_back(v(0,1,1,1,32'h200,0,    1,32'h4,   1,32'h0));
        tv.push_back(v(0,0,1,0,0,0,          1,32'h200, 0,32'h0));
        tv.push_back(v(0,1,1,0,0,0,          1,32'h200, 0,32'h0));
        tv.push_back(v(0,0,1,0,0,0,          1,32'h204, 1,32'h200));

        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            @(negedge clk);
            chk($sformatf("tv%0d_req", i), mem_req, tv[i].e_req);
            if (tv[i].e_req) chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].e_addr);
            chk($sformatf("tv%0d_valid", i), instr_valid, tv[i].e_val);
            if (tv[i].e_val) begin
                chk($sformatf("tv%0d_pc", i), instr_pc, tv[i].e_pc);
                chk($sformatf("tv%0d_instr", i), instr, word_of(tv[i].e_pc));
            end
            mem_ack     = tv[i].ack;
            mem_rdata   = tv[i].bad_data ? 32'hDEAD_BEEF : word_of(mem_addr);
            instr_ready = tv[i].rdy;
            redirect    = tv[i].rdr;
            redirect_pc = tv[i].rpc;
        end

        // Asynchronous reset while a request is outstanding and the FIFO holds a word.
        do_reset();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = word_of(mem_addr); instr_ready = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("async_pre_valid", instr_valid, 1);
        chk("async_pre_req", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_valid", instr_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("async_restart_req", mem_req, 1);
        chk("async_restart_addr", mem_addr, 32'h0);
        chk("async_restart_valid", instr_valid, 0);

        // Fetch address wraps past 2^32 on the DEPTH=2 instance.
        begin
            logic [31:0] wa[$];
            logic [31:0] wexp [4];
            wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0; wexp[3] = 32'h4;
            @(negedge clk);
            reset_b = 1'b1;
            for (int k = 0; k < 20 && wa.size() < 4; k++) begin
                @(negedge clk);
                if (mem_req_b) begin
                    wa.push_back(mem_addr_b);
                    mem_ack_b   = 1'b1;
                    mem_rdata_b = word_of(mem_addr_b);
                end else begin
                    mem_ack_b = 1'b0;
                end
            end
            mem_ack_b = 1'b0;
            chk("wrap_count", wa.size(), 4);
            for (int k = 0; k < wa.size() && k < 4; k++)
                chk($sformatf("wrap_addr%0d", k), wa[k], wexp[k]);
        end

        // Randomized traffic against a queue model of delivered PCs.
        begin
            logic [31:0] q[$];
            logic [31:0] m_pc;
            bit          m_req, drain, a, rdy, rdr, byp, nxt_req;
            logic [31:0] rpc;
            int          delivered, rdy_pct;
            do_reset();
            m_pc = 32'h0; m_req = 1'b1; drain = 1'b0; delivered = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                case ((cyc / 500) % 3)
                    0:       rdy_pct = 90;
                    1:       rdy_pct = 25;
                    default: rdy_pct = 60;
                endcase
                a   = mem_req && ($urandom_range(2) != 0);
                rdy = ($urandom_range(99) < rdy_pct);
                rdr = ($urandom_range(19) == 0);
                rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
                mem_ack = a; instr_ready = rdy; redirect = rdr; redirect_pc = rpc;
                mem_rdata = word_of(mem_addr);
                #1;
                byp = 1'b0;
`ifdef IFQ_BYPASS_EN
                byp = (q.size() == 0) && a && !drain && !rdr;
`endif
                chk("rnd_req", mem_req, m_req);
                if (m_req && !drain) chk("rnd_addr", mem_addr, m_pc);
                chk("rnd_valid", instr_valid, (q.size() != 0) || byp);
                if (q.size() != 0) begin
                    chk("rnd_pc", instr_pc, q[0]);
                    chk("rnd_instr", instr, word_of(q[0]));
                end else if (byp) begin
                    chk("rnd_byp_pc", instr_pc, m_pc);
                end
                if (((q.size() != 0) || byp) && rdy) delivered++;
                if (rdr) begin
                    q.delete();
                    nxt_req = m_req;
                    drain   = m_req && !a;
                    m_pc    = rpc & 32'hFFFF_FFFC;
                end else begin
                    if (q.size() != 0 && rdy) void'(q.pop_front());
                    if (a && !drain) begin
                        if (!(byp && rdy)) q.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                    end
                    if (m_req && (!a || drain)) nxt_req = 1'b1;
                    else                        nxt_req = (q.size() < DEPTH);
                    drain = drain && !a;
                end
                m_req = nxt_req;
            end
            mem_ack = 1'b0; redirect = 1'b0;
            chk("rnd_progress", (delivered > 300) ? 32'd1 : 32'd0, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
